// File: rtl/cs_resolve_pkg.sv
// Shared types and sizing helpers for the carry-save resolve stage.
// Optional range check is enabled with CS_RESOLVE_RANGE_CHECK_EN.
package cs_resolve_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   function automatic int ndig(input int k, input int w);
      return k / w;
   endfunction

   localparam int K_DEF = 8;
   localparam int W_DEF = 4;
   localparam int CNT_W = $clog2(ndig(K_DEF, W_DEF)) + 1;

endpackage

// File: rtl/cs_digit_slice.sv
// One W-bit digit: carry-chain add of two words, then borrow-chain
// subtract of the modulus digit from that sum.
module cs_digit_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] s0_i,
   input  logic [W-1:0] s1_i,
   input  logic [W-1:0] n_i,
   input  logic         c_i,
   input  logic         b_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] diff_o,
   output logic         c_o,
   output logic         b_o
);

   logic [W:0] add_w;
   logic [W:0] sub_w;

   always_comb begin
      add_w = {1'b0, s0_i} + {1'b0, s1_i} + (W+1)'(c_i);
      sub_w = {1'b0, add_w[W-1:0]} - {1'b0, n_i} - (W+1)'(b_i);
   end

   assign sum_o  = add_w[W-1:0];
   assign c_o    = add_w[W];
   assign diff_o = sub_w[W-1:0];
   assign b_o    = sub_w[W];

endmodule

// File: rtl/cs_resolve.sv
// Digit-serial resolve of a carry-save pair into (s0 + s1) mod n.
// Define CS_RESOLVE_RANGE_CHECK_EN to add the t >= 2n range_err flag.
module cs_resolve
   import cs_resolve_pkg::*;
#(
   parameter int K = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         start,
   input  logic [K-1:0] s0,
   input  logic [K-1:0] s1,
   input  logic [K-1:0] n,
   output logic         idle,
   output logic         valid,
   input  logic         ack,
   output logic [K-1:0] r
`ifdef CS_RESOLVE_RANGE_CHECK_EN
   ,
   output logic         range_err
`endif
);

   localparam int ND = ndig(K, W);
   localparam int CW = $clog2(ND) + 1;

   if (K % W != 0) begin : g_bad_w
      $error("cs_resolve: K must be a multiple of W");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          c_q, b_q;
   logic [K-1:0]  s0_q, s1_q, n_q;
   logic [K-1:0]  sum_q, diff_q, r_q;

   logic [W-1:0]  sum_dig, diff_dig;
   logic          c_d, b_d, last;
   logic [K-1:0]  sum_d, diff_d, sel_d;

   cs_digit_slice #(.W(W)) u_main (
      .s0_i   (s0_q[W-1:0]),
      .s1_i   (s1_q[W-1:0]),
      .n_i    (n_q[W-1:0]),
      .c_i    (c_q),
      .b_i    (b_q),
      .sum_o  (sum_dig),
      .diff_o (diff_dig),
      .c_o    (c_d),
      .b_o    (b_d)
   );

   assign last   = (cnt_q == CW'(ND - 1));
   assign sum_d  = (sum_q >> W) | (K'(sum_dig) << (K - W));
   assign diff_d = (diff_q >> W) | (K'(diff_dig) << (K - W));
   // Sum is only correct when t < n, i.e. no carry out and a net borrow
   assign sel_d  = (!c_d && b_d) ? sum_d : diff_d;

`ifdef CS_RESOLVE_RANGE_CHECK_EN
   logic         b2_q, msb_q, err_q;
   logic         b2_d, err_d;
   logic [W-1:0] twon_dig;
   logic [W-1:0] unused_s2, unused_d2;
   logic         unused_c2;

   assign twon_dig = (n_q[W-1:0] << 1) | W'(msb_q);

   cs_digit_slice #(.W(W)) u_twon (
      .s0_i   (sum_dig),
      .s1_i   ('0),
      .n_i    (twon_dig),
      .c_i    (1'b0),
      .b_i    (b2_q),
      .sum_o  (unused_s2),
      .diff_o (unused_d2),
      .c_o    (unused_c2),
      .b_o    (b2_d)
   );

   // Top bit of t is c_d, top bit of 2n is n[K-1]; t >= 2n iff no final borrow
   assign err_d = c_d ? !(n_q[W-1] && b2_d) : !(n_q[W-1] || b2_d);
   assign range_err = err_q;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN:  if (last) state_d = HOLD;
         HOLD: if (ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (ce) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         c_q    <= 1'b0;
         b_q    <= 1'b0;
         s0_q   <= '0;
         s1_q   <= '0;
         n_q    <= '0;
         sum_q  <= '0;
         diff_q <= '0;
         r_q    <= '0;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
         b2_q   <= 1'b0;
         msb_q  <= 1'b0;
         err_q  <= 1'b0;
`endif
      end else if (ce) begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  s0_q   <= s0;
                  s1_q   <= s1;
                  n_q    <= n;
                  c_q    <= 1'b0;
                  b_q    <= 1'b0;
                  cnt_q  <= '0;
                  sum_q  <= '0;
                  diff_q <= '0;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
                  b2_q   <= 1'b0;
                  msb_q  <= 1'b0;
`endif
               end
            end
            RUN: begin
               s0_q   <= s0_q >> W;
               s1_q   <= s1_q >> W;
               n_q    <= n_q >> W;
               c_q    <= c_d;
               b_q    <= b_d;
               sum_q  <= sum_d;
               diff_q <= diff_d;
               cnt_q  <= cnt_q + CW'(1);
`ifdef CS_RESOLVE_RANGE_CHECK_EN
               b2_q   <= b2_d;
               msb_q  <= n_q[W-1];
`endif
               if (last) begin
                  r_q <= sel_d;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
                  err_q <= err_d;
`endif
               end
            end
            HOLD: begin
`ifdef CS_RESOLVE_RANGE_CHECK_EN
               if (ack) err_q <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign idle  = (state_q == IDLE);
   assign valid = (state_q == HOLD);
   assign r     = r_q;

endmodule
